mono_readout_ctrl: RTL

//  Token-based readout sequencer for one front-end flavour of the matrix (PMOS_NOSF, PMOS, COMP or HV); four instances, one per flavour.

---
 rtl/mono_readout_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/mono_readout_ctrl.sv
// Token readout sequencer for one front-end flavour: freezes the double-columns,
// serves pending tokens lowest index first and streams {col, data} words downstream.
module mono_readout_ctrl #(
  parameter int NCOL          = 56,
  parameter int DATA_W        = 21,
  parameter int COL_W         = 6,
  parameter int FREEZE_SETTLE = 2,
  parameter int READ_PULSE    = 2,
  parameter int TOK_SETTLE    = 2
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     EN,
  input  logic [NCOL-1:0]          nTOK,
  input  logic [NCOL*DATA_W-1:0]   Data,
  output logic [NCOL-1:0]          FREEZE,
  output logic [NCOL-1:0]          Read,
  output logic [COL_W+DATA_W-1:0]  DATA_OUT,
  output logic                     DATA_VALID,
  input  logic                     DATA_READY,
  output logic                     BUSY,
  output logic [15:0]              HIT_CNT
);

  typedef enum logic [2:0] {IDLE, FRZ, SCAN, READ, OUT, TOKW, UNFRZ} state_t;

  state_t            state;
  logic [7:0]        cnt;
  logic [COL_W-1:0]  col;
  logic [COL_W-1:0]  scan_col;
  logic              hit;
  logic [DATA_W-1:0] col_data [NCOL];

  for (genvar g = 0; g < NCOL; g++) begin : g_col
    assign col_data[g] = Data[g*DATA_W +: DATA_W];
  end

  // Lowest pending column wins: scan high to low so the last match is the lowest.
  always_comb begin
    hit      = 1'b0;
    scan_col = '0;
    for (int c = NCOL-1; c >= 0; c--) begin
      if (!nTOK[c]) begin
        hit      = 1'b1;
        scan_col = COL_W'(c);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      cnt        <= '0;
      col        <= '0;
      FREEZE     <= '0;
      Read       <= '0;
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      BUSY       <= 1'b0;
      HIT_CNT    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (EN && !(&nTOK)) begin
            state  <= FRZ;
            FREEZE <= '1;
            BUSY   <= 1'b1;
            cnt    <= '0;
          end
        end
        FRZ: begin
          if (cnt == 8'(FREEZE_SETTLE-1)) state <= SCAN;
          else                             cnt   <= cnt + 8'd1;
        end
        SCAN: begin
          if (hit && EN) begin
            state <= READ;
            col   <= scan_col;
            Read  <= {{(NCOL-1){1'b0}}, 1'b1} << scan_col;
            cnt   <= '0;
          end else begin
            state  <= UNFRZ;
            FREEZE <= '0;
          end
        end
        READ: begin
          if (cnt == 8'(READ_PULSE-1)) begin
            state      <= OUT;
            Read       <= '0;
            DATA_OUT   <= {col, col_data[col]};
            DATA_VALID <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        OUT: begin
          if (DATA_READY) begin
            state      <= TOKW;
            DATA_VALID <= 1'b0;
            cnt        <= '0;
            if (HIT_CNT != 16'hFFFF) HIT_CNT <= HIT_CNT + 16'd1;
          end
        end
        TOKW: begin
          // Give the column time to release its token before re-scanning.
          if (cnt == 8'(TOK_SETTLE-1)) state <= SCAN;
          else                          cnt   <= cnt + 8'd1;
        end
        UNFRZ: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
